// File: rtl/fifo_if.sv
// rtl/fifo_if.sv - producer/consumer handshake bundle for the fifo block
//
// Purpose: groups the FIFO data and status signals so the producer/consumer
// side and the FIFO itself connect through a single port.
// Signals:
//   data_in   write data from the producer
//   wr        write request, level-sensitive
//   rd        read request, level-sensitive
//   data_out  registered read data
//   empty     fifo_cnt == 0
//   full      fifo_cnt == DEPTH
//   fifo_cnt  number of stored entries
// Modports:
//   master    producer/consumer side (drives data_in, wr, rd)
//   slave     FIFO side (drives data_out, empty, full, fifo_cnt)
interface fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 4
);
  logic [DATA_WIDTH-1:0] data_in;
  logic                  wr;
  logic                  rd;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  empty;
  logic                  full;
  logic [CNT_WIDTH-1:0]  fifo_cnt;

  modport master (
    output data_in, wr, rd,
    input  data_out, empty, full, fifo_cnt
  );

  modport slave (
    input  data_in, wr, rd,
    output data_out, empty, full, fifo_cnt
  );
endinterface

// File: rtl/fifo.sv
// rtl/fifo.sv - single-clock 8x8 FIFO with registered read data
//
// Purpose: synchronous first-in/first-out buffer between a producer and a
// consumer in the same clock domain. Popped data appears on data_out right
// after the clock edge that accepts the read.
// Ports:
//   clk  single clock, all state updates on the rising edge
//   rst  synchronous active-low reset
//   bus  fifo_if slave modport (data_in, wr, rd in; data_out, empty, full,
//        fifo_cnt out)
module fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int CNT_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic   clk,
  input  logic   rst,
  fifo_if.slave  bus
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic [DATA_WIDTH-1:0] r_data_out;

  logic w_empty;
  logic w_full;
  logic w_wr_en;
  logic w_rd_en;

  // Flags decode the count directly so they move in the same cycle as it.
  assign w_empty = (r_cnt == '0);
  assign w_full  = (r_cnt == CNT_WIDTH'(DEPTH));

  // A write while full and a read while empty are simply not accepted;
  // this also resolves the simultaneous wr/rd cases at the boundaries.
  assign w_wr_en = bus.wr && !w_full;
  assign w_rd_en = bus.rd && !w_empty;

  // Storage is not reset: stale entries are unreachable once the pointers
  // and count are cleared.
  always_ff @(posedge clk) begin
    if (rst && w_wr_en) begin
      r_mem[r_wr_ptr] <= bus.data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_cnt      <= '0;
      r_data_out <= '0;
    end else begin
      if (w_wr_en) begin
        // Pointer width equals log2(DEPTH), so overflow is the modulo wrap.
        r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
      end
      if (w_rd_en) begin
        // Reads the old array contents, so a same-cycle write never bypasses.
        r_data_out <= r_mem[r_rd_ptr];
        r_rd_ptr   <= r_rd_ptr + ADDR_WIDTH'(1);
      end
      case ({w_wr_en, w_rd_en})
        2'b10:   r_cnt <= r_cnt + CNT_WIDTH'(1);
        2'b01:   r_cnt <= r_cnt - CNT_WIDTH'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign bus.data_out = r_data_out;
  assign bus.empty    = w_empty;
  assign bus.full     = w_full;
  assign bus.fifo_cnt = r_cnt;

endmodule

// File: tb/tb_fifo.sv
// tb/tb_fifo.sv - scoreboard bench for the fifo block
module tb_fifo;

  localparam int DEPTH = 8;

  typedef struct {
    logic [7:0] dout;
    int         cnt;
    string      tag;
  } exp_t;

  logic clk;
  logic rst;

  fifo_if #(.DATA_WIDTH(8), .CNT_WIDTH(4)) bus ();

  fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .CNT_WIDTH(4)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a plain queue holding the stored words plus the last
  // word handed to the consumer.
  logic [7:0] model_q[$];
  logic [7:0] model_dout;
  exp_t       sb_q[$];

  int n_tests;
  int n_fail;

  // One clock cycle of stimulus: drive at the falling edge, advance the
  // model by the rules for the coming rising edge, queue the expected state.
  task automatic cycle(input logic r, input logic w, input logic rd_req,
                       input logic [7:0] din, input string tag);
    bit   do_wr;
    bit   do_rd;
    exp_t e;
    @(negedge clk);
    rst         = r;
    bus.wr      = w;
    bus.rd      = rd_req;
    bus.data_in = din;
    if (!r) begin
      model_q.delete();
      model_dout = 8'd0;
    end else begin
      do_wr = w && (model_q.size() < DEPTH);
      do_rd = rd_req && (model_q.size() > 0);
      if (do_rd) model_dout = model_q.pop_front();
      if (do_wr) model_q.push_back(din);
    end
    e.dout = model_dout;
    e.cnt  = model_q.size();
    e.tag  = tag;
    sb_q.push_back(e);
  endtask

  // Monitor: after each rising edge, compare the DUT outputs to the oldest
  // pending expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        n_tests++;
        if (bus.data_out !== e.dout) begin
          n_fail++;
          $display("FAIL %s data_out: got %0d expected %0d", e.tag, bus.data_out, e.dout);
        end
        n_tests++;
        if (bus.fifo_cnt !== 4'(e.cnt)) begin
          n_fail++;
          $display("FAIL %s fifo_cnt: got %0d expected %0d", e.tag, bus.fifo_cnt, e.cnt);
        end
        n_tests++;
        if (bus.empty !== (e.cnt == 0)) begin
          n_fail++;
          $display("FAIL %s empty: got %0b expected %0b", e.tag, bus.empty, (e.cnt == 0));
        end
        n_tests++;
        if (bus.full !== (e.cnt == DEPTH)) begin
          n_fail++;
          $display("FAIL %s full: got %0b expected %0b", e.tag, bus.full, (e.cnt == DEPTH));
        end
      end
    end
  end

  initial begin
    logic [7:0] v;
    int         waited;
    n_tests     = 0;
    n_fail      = 0;
    model_dout  = 8'd0;
    rst         = 1'b0;
    bus.wr      = 1'b0;
    bus.rd      = 1'b0;
    bus.data_in = 8'd0;

    // Reset then idle
    cycle(1'b0, 1'b0, 1'b0, 8'd0, "reset");
    cycle(1'b0, 1'b0, 1'b0, 8'd0, "reset");
    cycle(1'b1, 1'b0, 1'b0, 8'd0, "idle");

    // Basic order
    cycle(1'b1, 1'b1, 1'b0, 8'd1, "push1");
    cycle(1'b1, 1'b1, 1'b1, 8'd2, "wr2_rd");
    cycle(1'b1, 1'b0, 1'b1, 8'd0, "pop2");

    // Fill and overflow
    for (int i = 1; i <= 8; i++) cycle(1'b1, 1'b1, 1'b0, 8'(i * 10), "fill");
    for (int i = 9; i <= 13; i++) cycle(1'b1, 1'b1, 1'b0, 8'(i * 10), "overflow");
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 1'b1, 8'd0, "drain");

    // Wrap-around: keep the FIFO full while recirculating the oldest word
    for (int i = 1; i <= 8; i++) cycle(1'b1, 1'b1, 1'b0, 8'(i * 10), "refill");
    for (int i = 0; i < 12; i++) begin
      v = model_q[0];
      cycle(1'b1, 1'b0, 1'b1, 8'd0, "wrap_pop");
      cycle(1'b1, 1'b1, 1'b0, v, "wrap_push");
    end
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 1'b1, 8'd0, "wrap_drain");

    // Underflow
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b1, 8'd0, "underflow");
    cycle(1'b1, 1'b1, 1'b0, 8'd5, "push5");
    cycle(1'b1, 1'b0, 1'b1, 8'd0, "pop5");

    // Simultaneous wr+rd at the boundaries
    cycle(1'b1, 1'b1, 1'b1, 8'd77, "wrrd_empty");
    for (int i = 0; i < 7; i++) cycle(1'b1, 1'b1, 1'b0, 8'(100 + i), "fill2");
    cycle(1'b1, 1'b1, 1'b1, 8'd200, "wrrd_full");
    cycle(1'b1, 1'b1, 1'b1, 8'd201, "wrrd_mid");

    // Reset in the middle of a burst
    cycle(1'b1, 1'b1, 1'b0, 8'd33, "burst");
    cycle(1'b0, 1'b1, 1'b1, 8'd34, "rst_burst");
    cycle(1'b1, 1'b0, 1'b0, 8'd0, "post_rst");

    // Randomized traffic with occasional reset
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 199) != 0),
            1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)),
            8'($urandom_range(0, 255)),
            "random");
    end
    cycle(1'b1, 1'b0, 1'b0, 8'd0, "final_idle");

    waited = 0;
    while (sb_q.size() > 0 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    @(posedge clk);
    #2;
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_scoreboard: got %0d pending expected 0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
